// File: rtl/crc_engine.sv
// crc_engine: parametrised, frame-aware CRC generator/checker.
// It processes one beat of DATA_W/8 bytes per clock under a valid/ready handshake.
// It strobes the finished CRC for one cycle after the last beat of each frame.
// Optional macro CRC_ENGINE_CHECK_EN adds i_exp_crc / o_crc_ok for receive-side checking.
module crc_engine #(
  parameter int unsigned CRC_W  = 12,
  parameter logic [31:0] POLY   = 32'h80F,
  parameter logic [31:0] INIT   = 32'h0,
  parameter logic [31:0] XOROUT = 32'h0,
  parameter int unsigned DATA_W = 8,
  parameter bit          REFIN  = 1'b0,
  parameter bit          REFOUT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_last,
`ifdef CRC_ENGINE_CHECK_EN
  input  logic [CRC_W-1:0]  i_exp_crc,
  output logic              o_crc_ok,
`endif
  output logic              o_crc_valid,
  output logic [CRC_W-1:0]  o_crc,
  output logic              o_busy
);

  localparam int unsigned      NBytes = DATA_W / 8;
  localparam logic [CRC_W-1:0] PolyW  = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] InitW  = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XorW   = XOROUT[CRC_W-1:0];

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [CRC_W-1:0] r_crc, r_crc_out;
  logic [CRC_W-1:0] w_crc_start, w_crc_next, w_crc_fin;
  logic             w_accept;

  // One byte, MSB first; each data bit enters at the register MSB, so CRC_W < 8 also works.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c_in,
                                                input logic [7:0]       b_in);
    logic [CRC_W-1:0] c;
    logic [7:0]       b;
    logic             fb;
    c = c_in;
    for (int i = 0; i < 8; i++) b[i] = REFIN ? b_in[7-i] : b_in[i];
    for (int i = 7; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ b[i];
      c  = c << 1;
      if (fb) c = c ^ PolyW;
    end
    return c;
  endfunction

  // Output transform: optional full-register reversal, then XOROUT.
  function automatic logic [CRC_W-1:0] crc_final(input logic [CRC_W-1:0] c_in);
    logic [CRC_W-1:0] c;
    for (int i = 0; i < CRC_W; i++) c[i] = REFOUT ? c_in[CRC_W-1-i] : c_in[i];
    return c ^ XorW;
  endfunction

  // Unrolled per-beat update; the first beat of a frame always starts from INIT.
  always_comb begin
    w_crc_start = (r_state == StIdle) ? InitW : r_crc;
    w_crc_next  = w_crc_start;
    for (int k = 0; k < NBytes; k++) w_crc_next = crc_byte(w_crc_next, i_s_data[8*k +: 8]);
    w_crc_fin   = crc_final(w_crc_next);
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    o_s_ready    = (r_state != StDone);
    o_busy       = (r_state == StRun);
    o_crc_valid  = (r_state == StDone);
    w_accept     = i_s_valid && o_s_ready;
    case (r_state)
      StIdle, StRun: if (w_accept) w_state_next = i_s_last ? StDone : StRun;
      StDone:        w_state_next = StIdle;
      default:       w_state_next = StIdle;
    endcase
  end

  // State, running CRC register and held output value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_crc     <= InitW;
      r_crc_out <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StDone) begin
        r_crc <= InitW;
      end else if (w_accept) begin
        r_crc <= w_crc_next;
        if (i_s_last) r_crc_out <= w_crc_fin;
      end
    end
  end

  assign o_crc = r_crc_out;

`ifdef CRC_ENGINE_CHECK_EN
  logic r_ok;

  // Compare against the expected CRC sampled with the last beat; only shown during the strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ok <= 1'b0;
    end else if (w_accept && i_s_last) begin
      r_ok <= (w_crc_fin == i_exp_crc);
    end
  end

  assign o_crc_ok = r_ok && o_crc_valid;
`endif

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: directed, scoreboard-checked bench for crc_engine.
// Four byte-wide instances (CRC-12/DECT, CRC-12/UMTS, CRC-8, CRC-16/CCITT-FALSE) share a single stream.
// A DATA_W=32 CRC-16 instance has its own stream.
module tb_crc_engine;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [11:0] dect;
    logic [11:0] umts;
    logic [7:0]  c8;
    logic [15:0] c16;
    bit          ok;
  } exp_t;

  logic        clk, rst;
  logic        s_valid, s_last;
  logic [7:0]  s_data;
  logic [3:0]  rdy, crcv, busy;
  logic [11:0] crc_dect, crc_umts;
  logic [7:0]  crc_c8;
  logic [15:0] crc_c16;

  logic        w_valid, w_last, w_rdy, w_crcv, w_busy;
  logic [31:0] w_data;
  logic [15:0] w_crc;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  exp_t        sb[$];
  logic [15:0] wsb[$];
  exp_t        m_e;
  logic [15:0] m_w;

`ifdef CRC_ENGINE_CHECK_EN
  logic [11:0] exp_crc;
  logic [4:0]  crc_ok;
`endif

  crc_engine u_dect (
    .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(rdy[0]), .i_s_data(s_data),
    .i_s_last(s_last),
`ifdef CRC_ENGINE_CHECK_EN
    .i_exp_crc(exp_crc), .o_crc_ok(crc_ok[0]),
`endif
    .o_crc_valid(crcv[0]), .o_crc(crc_dect), .o_busy(busy[0])
  );

  crc_engine #(.REFOUT(1'b1)) u_umts (
    .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(rdy[1]), .i_s_data(s_data),
    .i_s_last(s_last),
`ifdef CRC_ENGINE_CHECK_EN
    .i_exp_crc(12'h000), .o_crc_ok(crc_ok[1]),
`endif
    .o_crc_valid(crcv[1]), .o_crc(crc_umts), .o_busy(busy[1])
  );

  crc_engine #(.CRC_W(8), .POLY(32'h07)) u_c8 (
    .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(rdy[2]), .i_s_data(s_data),
    .i_s_last(s_last),
`ifdef CRC_ENGINE_CHECK_EN
    .i_exp_crc(8'h00), .o_crc_ok(crc_ok[2]),
`endif
    .o_crc_valid(crcv[2]), .o_crc(crc_c8), .o_busy(busy[2])
  );

  crc_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF)) u_c16 (
    .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(rdy[3]), .i_s_data(s_data),
    .i_s_last(s_last),
`ifdef CRC_ENGINE_CHECK_EN
    .i_exp_crc(16'h0000), .o_crc_ok(crc_ok[3]),
`endif
    .o_crc_valid(crcv[3]), .o_crc(crc_c16), .o_busy(busy[3])
  );

  crc_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .DATA_W(32)) u_wide (
    .i_clk(clk), .i_rst(rst), .i_s_valid(w_valid), .o_s_ready(w_rdy), .i_s_data(w_data),
    .i_s_last(w_last),
`ifdef CRC_ENGINE_CHECK_EN
    .i_exp_crc(16'h0000), .o_crc_ok(crc_ok[4]),
`endif
    .o_crc_valid(w_crcv), .o_crc(w_crc), .o_busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference CRC (non-reflected input): XOR byte into the top, then shift 8 times.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input bit refout,
                                          input bytes_t msg);
    logic [31:0] mask, c, r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    c = init & mask;
    foreach (msg[i]) begin
      c = c ^ (32'(msg[i]) << (w - 8));
      for (int k = 0; k < 8; k++) c = c[w-1] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
    end
    r = c;
    if (refout) for (int k = 0; k < w; k++) r[k] = c[w-1-k];
    return r;
  endfunction

  function automatic bytes_t str2q(input string s);
    bytes_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Byte-stream monitor: strobe contents against the scoreboard, ready low only in DONE.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_not_done", 32'(rdy[0]), 32'(!crcv[0]));
`ifdef CRC_ENGINE_CHECK_EN
      if (!crcv[0]) check("crc_ok_idle", 32'(crc_ok[0]), 32'h0);
`endif
      if (crcv[0]) begin
        if (sb.size() == 0) begin
          check("spurious_strobe", 32'(crcv[0]), 32'h0);
        end else begin
          m_e = sb.pop_front();
          check("crc_dect", 32'(crc_dect), 32'(m_e.dect));
          check("crc_umts", 32'(crc_umts), 32'(m_e.umts));
          check("crc_c8",   32'(crc_c8),   32'(m_e.c8));
          check("crc_c16",  32'(crc_c16),  32'(m_e.c16));
          check("strobe_all", 32'(crcv), 32'hF);
`ifdef CRC_ENGINE_CHECK_EN
          check("crc_ok", 32'(crc_ok[0]), 32'(m_e.ok));
`endif
        end
      end
    end
  end

  // Wide-stream monitor.
  always @(negedge clk) begin
    if (!rst) begin
      check("w_ready_not_done", 32'(w_rdy), 32'(!w_crcv));
      if (w_crcv) begin
        if (wsb.size() == 0) begin
          check("w_spurious_strobe", 32'(w_crcv), 32'h0);
        end else begin
          m_w = wsb.pop_front();
          check("w_crc", 32'(w_crc), 32'(m_w));
        end
      end
    end
  end

  // Drive one frame on the byte stream; has_last=0 sends a partial frame.
  task automatic send(input bytes_t msg, input int gap_max, input bit has_last,
                      input exp_t e, input logic [11:0] expc);
    for (int i = 0; i < msg.size(); i++) begin
      bit acc;
      int tmo;
      int g;
      s_valid = 1'b1;
      s_data  = msg[i];
      s_last  = has_last && (i == msg.size() - 1);
      if (s_last) sb.push_back(e);
`ifdef CRC_ENGINE_CHECK_EN
      exp_crc = s_last ? expc : 12'hXXX;
`else
      if (expc === 12'hXXX) s_data = msg[i];
`endif
      tmo = 0;
      do begin
        acc = rdy[0];
        @(posedge clk);
        #1;
        tmo++;
      end while (!acc && tmo < 20);
      if (!acc) check("accept_timeout", 32'(acc), 32'h1);
      check("busy_after_beat", 32'(busy[0]), 32'(!s_last));
      if (s_last) check("strobe_latency", 32'(crcv[0]), 32'h1);
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Drive one frame of 32-bit beats on the wide stream.
  task automatic send_w(input bytes_t msg, input int gap_max, input logic [15:0] e);
    int nb;
    nb = msg.size() / 4;
    for (int i = 0; i < nb; i++) begin
      bit acc;
      int tmo;
      int g;
      w_valid = 1'b1;
      w_data  = {msg[4*i+3], msg[4*i+2], msg[4*i+1], msg[4*i]};
      w_last  = (i == nb - 1);
      if (w_last) wsb.push_back(e);
      tmo = 0;
      do begin
        acc = w_rdy;
        @(posedge clk);
        #1;
        tmo++;
      end while (!acc && tmo < 20);
      if (!acc) check("w_accept_timeout", 32'(acc), 32'h1);
      check("w_busy_after_beat", 32'(w_busy), 32'(!w_last));
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        w_valid = 1'b0;
        w_data  = $urandom;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  initial begin
    bytes_t chk, zero, part, w8;
    exp_t   e_chk, e_bad, e_zero;
    logic [15:0] e_w;

    chk  = str2q("123456789");
    part = str2q("1234");
    w8   = str2q("12345678");
    zero = {8'h00};
    e_chk  = '{dect: 12'hF5B, umts: 12'hDAF, c8: 8'hF4, c16: 16'h29B1, ok: 1'b1};
    e_bad  = e_chk;
    e_bad.ok = 1'b0;
    e_zero = '{dect: 12'h000, umts: 12'h000, c8: 8'h00,
               c16: 16'(ref_crc(16, 32'h1021, 32'hFFFF, 1'b0, zero)), ok: 1'b1};
    e_w    = 16'(ref_crc(16, 32'h1021, 32'hFFFF, 1'b0, w8));

    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    w_valid = 1'b0; w_last = 1'b0; w_data = 32'h0;
`ifdef CRC_ENGINE_CHECK_EN
    exp_crc = 12'h000;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_crc",       32'(crc_dect), 32'h0);
    check("rst_crc_valid", 32'(crcv),     32'h0);
    check("rst_ready",     32'(rdy),      32'hF);
    check("rst_busy",      32'(busy),     32'h0);
    check("rst_w_crc",     32'(w_crc),    32'h0);
    rst = 1'b0;

    // Back-to-back "123456789", then with random gaps, then back-to-back again.
    send(chk, 0, 1'b1, e_chk, 12'hF5B);
    send(chk, 5, 1'b1, e_chk, 12'hF5B);
    send(chk, 0, 1'b1, e_bad, 12'hF5A);
    send(chk, 0, 1'b1, e_chk, 12'hF5B);

    // Abort a frame with reset after 4 bytes; no strobe may follow for it.
    send(part, 0, 1'b0, e_chk, 12'hF5B);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy",  32'(busy[0]), 32'h0);
    check("abort_ready", 32'(rdy[0]),  32'h1);
    check("abort_crcv",  32'(crcv[0]), 32'h0);
    send(chk, 2, 1'b1, e_chk, 12'hF5B);

    // Single-byte frame.
    send(zero, 0, 1'b1, e_zero, 12'h000);

    // Wide instance: two 32-bit beats, back-to-back frames and a gapped frame.
    send_w(w8, 0, e_w);
    send_w(w8, 0, e_w);
    send_w(w8, 4, e_w);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained",  32'(sb.size()),  32'h0);
    check("wsb_drained", 32'(wsb.size()), 32'h0);
    check("crc_held",    32'(crc_dect),   32'h000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc_engine.md
Name: crc_engine

Overview:
- Parametrised, frame-aware CRC generator/checker; successor to the fixed CRC-12 byte engine in the transceiver datapath.
- Accepts a byte-or-wider data stream under a valid/ready handshake and processes one beat per clock.
- Emits the finished CRC with a one-cycle strobe after the last beat of each frame.
- Supports any polynomial up to 32 bits, with configurable init, input/output reflection and final XOR.

Parameters:
- CRC_W, 12, CRC width in bits (1..32).
- POLY, 12'h80F, generator polynomial, normal form, implicit top bit omitted.
- INIT, 0, register value loaded at start of every frame.
- XOROUT, 0, value XORed into the register to form the output.
- DATA_W, 8, data beat width; multiple of 8, 8..64.
- REFIN, 0, 1 = bit-reverse each input byte before processing (LSB first).
- REFOUT, 0, 1 = bit-reverse the full CRC register before XOROUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  engine can accept a beat.
- s_data  in  DATA_W  beat data; byte 0 is [7:0] and is processed first.
- s_last  in  1  marks the final beat of a frame.
- crc_valid  out  1  one-cycle strobe: crc holds the final value.
- crc  out  CRC_W  final CRC (REFOUT, then XOROUT applied).
- busy  out  1  frame in progress (at least one beat accepted, last not yet accepted).

Behaviour:
- Reset and clock: one clock domain; rst is synchronous, active-high, and overrides all other inputs.
- Reset values: state=IDLE, CRC register=INIT, s_ready=1, crc_valid=0, crc=0, busy=0.
- Handshake: a beat is accepted on a rising edge when s_valid && s_ready. s_ready is combinational from state only: 1 in IDLE and RUN, 0 in DONE. s_data and s_last are ignored when the beat is not accepted.
- Per-beat update: each accepted beat updates the register by DATA_W/8 bytes in one cycle (unrolled MSB-first shift per byte, applying REFIN per byte). The first beat of a frame uses INIT as the starting register, not the stale value.
- FSM:
  - IDLE: accept with s_last=0 -> RUN; accept with s_last=1 -> DONE.
  - RUN: accept with s_last=1 -> DONE; otherwise stay in RUN.
  - DONE: crc_valid=1 and crc=final for exactly this cycle; the register reloads INIT; next state is IDLE unconditionally.
- Latency: crc_valid rises in the cycle after the s_last beat is accepted. A new frame can start 2 cycles after s_last is accepted, giving 1 bubble per frame.
- crc holds its last value until the next DONE; only crc_valid marks freshness.
- Single-beat frame (s_last on the first beat) is legal and yields the CRC of that beat. Zero-length frames are not representable.
- Idle gaps: deasserting s_valid mid-frame holds the register; gaps of any length are legal.
- Reset mid-frame: the partial frame is discarded and no crc_valid is generated. The next beat starts a new frame from INIT.
- s_valid in DONE: stalled, because s_ready=0; the producer must hold the beat.
- Width rules: the register is CRC_W bits; POLY, INIT and XOROUT are truncated to CRC_W. For CRC_W < 8, the data byte's bits are fed serially into the register MSB.

Optional Feature:
- Macro: CRC_ENGINE_CHECK_EN.
- Defined:
  - Adds input exp_crc [CRC_W-1:0], sampled together with the s_last beat.
  - Adds output crc_ok (1 bit, reset 0), valid only while crc_valid=1: crc_ok = (crc == sampled exp_crc). crc_ok=0 in all other cycles.
  - Used in receive mode to flag corrupted frames.
- Undefined: neither port exists and generate-only behaviour is unchanged.

Test Plan:
- CRC-12/DECT (defaults: POLY 80F, INIT 0, no reflection, XOROUT 0), DATA_W=8, ASCII "123456789" as 9 back-to-back beats with last on '9' -> single crc_valid strobe one cycle after the last beat, crc=12'hF5B; busy high from beat 1 through beat 9.
- Same stream with random s_valid gaps of 0-5 cycles, then a second back-to-back frame -> both frames give 12'hF5B; s_ready=0 only in each DONE cycle.
- CRC_W=16, POLY 1021, INIT FFFF, DATA_W=32, "123456789" packed as 3 beats (last beat holds '9' in byte 0, upper bytes excluded via a DATA_W=8 tail variant) -> crc=16'h29B1; separately CRC-8 POLY 07, DATA_W=8 -> crc=8'hF4.
- Reflection: CRC_W=12, POLY 80F, REFOUT=1 (CRC-12/UMTS), "123456789" -> crc=12'hDAF.
- rst pulsed after 4 bytes of a frame, then the full "123456789" -> no strobe for the aborted frame; next strobe crc=12'hF5B. Single-byte frame 8'h00 -> crc=12'h000.
- With CRC_ENGINE_CHECK_EN defined, exp_crc=12'hF5B -> crc_ok=1 on the strobe; exp_crc=12'hF5A -> crc_ok=0; crc_ok=0 in all non-strobe cycles.
